mux_arb_nto1: RTL

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake. Channel choice is either an explicit select input or round-robin arbitration. The output is a single-entry pipeline register that sustains full throughput. It replaces the fixed 4:1 bit-select muxes wherever a datapath needs stall-aware source selection, such as writeback source, operand forwarding or bus master select.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/rr_arbiter_n.sv | 75 +++++++
 rtl/mux_arb_nto1.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants and helpers for the N:1 registered multiplexer/arbiter.
//   MUX_MODE_SEL / MUX_MODE_RR : values of the MODE parameter
//   STALL_CNT_W                : width of the stall statistics counter
//   clog2()                    : ceiling log2, never below 1 so that a
//                                2-channel mux still gets a 1-bit index
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;
  localparam int STALL_CNT_W  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n
// Round-robin arbiter over NUM_CH requesters (NUM_CH need not be a power
// of two). The search starts at the pointer and wraps NUM_CH-1 -> 0. The
// pointer moves to the channel after the winner when a transfer happens
// and returns to 0 on clear.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset (pointer -> 0)
//   req          : request vector, one bit per channel
//   advance      : a transfer on the current grant happens this cycle
//   clear        : synchronous pointer clear (wins over advance)
//   grant        : one-hot grant (all zero when no request)
//   grant_idx    : encoded index of the granted channel
//   grant_valid  : at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic              clear,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W:0]   cand;

  // Walk the channels in rotated order; the first requester wins. The
  // candidate is one bit wider than the index so ptr + offset can be
  // folded back below NUM_CH with a single subtraction.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      cand = {1'b0, ptr_reg} + (SEL_W+1)'(j);
      if (cand >= (SEL_W+1)'(NUM_CH)) cand = cand - (SEL_W+1)'(NUM_CH);
      if (!grant_valid && req[cand[SEL_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SEL_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
      assign grant[gi] = grant_valid && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    if (clear) begin
      ptr_next = '0;
    end else if (advance && grant_valid) begin
      ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// mux_arb_nto1
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes
// on every input and on the output. The channel is picked either by the
// sel input (MODE = MUX_MODE_SEL) or by a round-robin arbiter
// (MODE = MUX_MODE_RR). The output is a single register that reloads in
// the same cycle it is drained, so one word per cycle is sustained.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel accept, one-hot or zero
//   sel        : channel select (MODE 0 only; values >= NUM_CH grant nothing)
//   flush      : synchronous clear of output valid, rr pointer and stats
//   out_data   : registered selected data
//   out_ch     : index of the channel that produced out_data
//   out_valid  : output register holds a word
//   out_ready  : downstream accept
//   stall_cnt  : cycles with out_valid && !out_ready, saturating
//
// Build option
//   MUX_ARB_STATS_EN : when defined, stall_cnt is a live counter; when
//                      undefined, stall_cnt reads 0 and no counter exists.
// ---------------------------------------------------------------------------
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  parameter  int MODE   = MUX_MODE_SEL,
  localparam int SEL_W  = clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [STALL_CNT_W-1:0]  stall_cnt
);

  // Index space reachable by sel; may exceed NUM_CH when NUM_CH is not a
  // power of two.
  localparam int SEL_SPAN = 1 << SEL_W;

  logic [NUM_CH-1:0] grant_oh;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_valid;

  logic              load_ok;
  logic              accept;
  logic              xfer;

  logic [WIDTH-1:0]  ch_data [NUM_CH];
  logic [WIDTH-1:0]  sel_data;

  logic              out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]  out_data_reg,  out_data_next;
  logic [SEL_W-1:0]  out_ch_reg,    out_ch_next;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The register can take a word when empty or when it empties this cycle.
  assign load_ok = !out_valid_reg || out_ready;
  assign accept  = load_ok && !flush;
  assign xfer    = grant_valid && accept;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^sel;

      rr_arbiter_n #(
        .NUM_CH (NUM_CH)
      ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (in_valid),
        .advance     (xfer),
        .clear       (flush),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
      );
    end else begin : g_sel
      // Zero-extend the valid vector to the full sel range so that an
      // out-of-range sel lands on a padding 0 and grants nothing.
      logic [SEL_SPAN-1:0] valid_ext;
      assign valid_ext   = SEL_SPAN'(in_valid);
      assign grant_valid = valid_ext[sel];
      assign grant_idx   = sel;

      for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
        assign grant_oh[gi] = grant_valid && (sel == SEL_W'(gi));
      end
    end
  endgenerate

  // rst_n gates in_ready directly so nothing is accepted while reset is
  // held, even though the cleared register would otherwise allow a load.
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && accept && grant_oh[gi];
    end
  endgenerate

  assign sel_data = ch_data[grant_idx];

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    if (flush) begin
      out_valid_next = 1'b0;
    end else if (xfer) begin
      out_valid_next = 1'b1;
      out_data_next  = sel_data;
      out_ch_next    = grant_idx;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

`ifdef MUX_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (flush) begin
      stall_cnt_next = '0;
    end else if (out_valid_reg && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_reg <= '0;
    else        stall_cnt_reg <= stall_cnt_next;
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule
